exe_mem_pipe_reg: RTL and testbench
===================================

# exe_mem_pipe_reg

Parametrised EXE→MEM pipeline register with valid/ready handshake, stall back-pressure and flush. It carries the memory-control bits, destination register, ALU result and Rm value from the execute stage to the memory stage. Unlike a plain clocked register, it holds data under downstream stall, inserts bubbles on flush, and can optionally buffer a second entry (skid) so `in_ready` is driven from a register.

## Interface
- `WORD_WIDTH`, default 32: width of `alu_res` and `val_rm`.
- `REG_FILE_DEPTH`, default 4: width of the `dest` register index.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low. Asserted (0) clears all state immediately.
- `flush`  in  1: synchronous kill of all held entries and of the input offered this cycle.
- `in_valid`  in  1: the EXE stage offers an entry.
- `in_ready`  out  1: the block accepts an entry this cycle.
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in`  in  1 each: control bits.
- `dest_in`  in  `REG_FILE_DEPTH`: destination register index.
- `alu_res_in`, `val_rm_in`  in  `WORD_WIDTH`: payload words.
- `out_valid`  out  1: the head entry is valid.
- `out_ready`  in  1: the MEM stage consumes the head entry.
- `mem_r_en_out`, `mem_w_en_out`, `wb_en_out`  out  1 each: head control bits, gated by `out_valid`.
- `dest_out`  out  `REG_FILE_DEPTH`; `alu_res_out`, `val_rm_out`  out  `WORD_WIDTH`: head payload.

## Operation
- Accept happens when `in_valid && in_ready && !flush`. Consume happens when `out_valid && out_ready`.
- Control outputs are ANDed with `out_valid`, so a bubble never asserts a memory or writeback enable. Payload outputs keep their last loaded value while invalid.
- `flush`: all entries become invalid at the next edge. The same-cycle input is dropped and the same-cycle consume is irrelevant. Flush has priority over every other event.
- Without skid, there is one entry:
  - `in_ready = !out_valid || out_ready` (combinational).
  - Accept loads the head. Consume without accept clears `out_valid`. Simultaneous accept and consume replaces the head.
- With skid, the state machine is EMPTY / FULL / SKID:
  - EMPTY: accept → FULL (entry goes to head).
  - FULL: accept without consume → SKID (entry goes to skid slot). Consume without accept → EMPTY. Accept and consume together → FULL with the new head.
  - SKID: `in_ready = 0`. Consume → FULL, with the skid slot promoted to head.
  - `in_ready = (state != SKID)` is a registered decode with no combinational path from `out_ready`.
- Ordering is strictly FIFO and no entry is ever duplicated or lost except by flush.

## Timing
- Reset values (while `rst = 0`): `out_valid = 0`; all control outputs 0; `dest_out = 0`; `alu_res_out = 0`; `val_rm_out = 0`; state EMPTY.
  - `in_ready` is 1 in skid mode and 1 in non-skid mode (`out_valid` is 0).
- Reset deasserting mid-stream discards all entries. The first accept is possible on the first edge after release.
- Latency: an entry accepted at edge N appears on the outputs with `out_valid = 1` after edge N.
- Throughput is 1 entry per cycle in both modes while `out_ready = 1`.
- `in_ready` in skid mode drops in the cycle after the block enters SKID. It rises in the cycle after the skid slot drains.

## Configuration
- Macro: `EXE_MEM_PIPE_SKID_EN`.
- Defined: two-entry skid buffer with the EMPTY/FULL/SKID state machine and registered `in_ready`.
- Undefined: single entry; `in_ready` is combinational from `out_ready`; the skid slot and state register are not built.
- Port list and reset behaviour are identical in both builds.

## Structure
- Shared constants package/header: `WORD_WIDTH` and `REG_FILE_DEPTH` defaults, a packed payload struct/width constant for {mem_r_en, mem_w_en, wb_en, dest, alu_res, val_rm}, and the state encoding (EMPTY=0, FULL=1, SKID=2).
- One natural sub-module: `pipe_slot`, a payload register with load enable, async active-low clear and a valid bit. It is instantiated once for the head and, in the skid build, once more for the skid slot.

## Test plan
- Reset: hold `rst = 0` with `in_valid = 1` and `alu_res_in = 0xDEADBEEF`. Expect `out_valid = 0`, all outputs 0 and no entry after release until a real accept.
- Streaming: send 8 entries (`alu_res_in` 1..8, `dest_in` = i mod 16) with `out_ready` held at 1. Expect outputs 1..8 in order on consecutive cycles, each one cycle after its accept.
- Stall:
  - Skid build: drop `out_ready` for 3 cycles while `in_valid = 1` with values 0x10, 0x11, 0x12. Expect `in_ready` low from the second stall cycle, and outputs 0x10, 0x11, 0x12 in order after `out_ready` returns.
  - Non-skid build: expect `in_ready` to follow `out_ready` in the same cycle.
- Flush in SKID state: fill two entries (0xA, 0xB), then assert `flush` together with `in_valid` (0xC) and `out_ready`. Expect `out_valid = 0` next cycle, `mem_w_en_out = 0`, and 0xC never emitted.
- Bubble gating: accept an entry with `mem_w_en_in = 1` and consume it. Then idle. Expect `mem_w_en_out = 0` while `alu_res_out` holds the last value.
- Async reset mid-stream: pull `rst` low between clock edges while in the FULL state. Expect `out_valid = 0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared constants for the EXE->MEM pipeline register: default widths, payload
// layout and the skid state encoding.
package exe_mem_pipe_reg_pkg;

  localparam int WORD_WIDTH_DEF     = 32;
  localparam int REG_FILE_DEPTH_DEF = 4;
  localparam int CTRL_W             = 3;

  // Payload layout at default widths, MSB first.
  typedef struct packed {
    logic                          mem_r_en;
    logic                          mem_w_en;
    logic                          wb_en;
    logic [REG_FILE_DEPTH_DEF-1:0] dest;
    logic [WORD_WIDTH_DEF-1:0]     alu_res;
    logic [WORD_WIDTH_DEF-1:0]     val_rm;
  } payload_t;

  localparam int PAYLOAD_W_DEF = $bits(payload_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  function automatic int payload_width(input int word_w, input int dest_w);
    return CTRL_W + dest_w + 2 * word_w;
  endfunction

endpackage

// File: rtl/exe_mem_pipe_reg_if.sv
// EXE->MEM link: upstream offer/accept, downstream offer/consume and flush.
// master = pipeline surroundings (EXE and MEM stages), slave = the register.
interface exe_mem_pipe_reg_if
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int REG_FILE_DEPTH = REG_FILE_DEPTH_DEF
);

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic                      mem_r_en_in;
  logic                      mem_w_en_in;
  logic                      wb_en_in;
  logic [REG_FILE_DEPTH-1:0] dest_in;
  logic [WORD_WIDTH-1:0]     alu_res_in;
  logic [WORD_WIDTH-1:0]     val_rm_in;
  logic                      out_valid;
  logic                      out_ready;
  logic                      mem_r_en_out;
  logic                      mem_w_en_out;
  logic                      wb_en_out;
  logic [REG_FILE_DEPTH-1:0] dest_out;
  logic [WORD_WIDTH-1:0]     alu_res_out;
  logic [WORD_WIDTH-1:0]     val_rm_out;

  modport master (
    output flush, in_valid, mem_r_en_in, mem_w_en_in, wb_en_in,
           dest_in, alu_res_in, val_rm_in, out_ready,
    input  in_ready, out_valid, mem_r_en_out, mem_w_en_out, wb_en_out,
           dest_out, alu_res_out, val_rm_out
  );

  modport slave (
    input  flush, in_valid, mem_r_en_in, mem_w_en_in, wb_en_in,
           dest_in, alu_res_in, val_rm_in, out_ready,
    output in_ready, out_valid, mem_r_en_out, mem_w_en_out, wb_en_out,
           dest_out, alu_res_out, val_rm_out
  );

endinterface

// File: rtl/exe_mem_pipe_reg_pipe_slot.sv
// One payload slot: data register with load enable plus a valid bit.
// Async active-low clear of both; flush clears only the valid bit.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  // Flush wins over load, load wins over drop (replace-on-consume).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready, stall hold and flush.
// Define EXE_MEM_PIPE_SKID_EN for a two-entry skid buffer with registered in_ready.
module exe_mem_pipe_reg
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int REG_FILE_DEPTH = REG_FILE_DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  exe_mem_pipe_reg_if.slave bus
);

  localparam int PW     = payload_width(WORD_WIDTH, REG_FILE_DEPTH);
  localparam int DEST_L = 2 * WORD_WIDTH;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] head_d;
  logic [PW-1:0] head_q;
  logic          head_valid;
  logic          head_load;
  logic          head_drop;
  logic          accept;
  logic          consume;
  logic          in_ready;

  assign in_payload = {bus.mem_r_en_in, bus.mem_w_en_in, bus.wb_en_in,
                       bus.dest_in, bus.alu_res_in, bus.val_rm_in};

  assign accept  = bus.in_valid && in_ready && !bus.flush;
  assign consume = head_valid && bus.out_ready;

  pipe_slot #(.W(PW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .load  (head_load),
    .drop  (head_drop),
    .d     (head_d),
    .q     (head_q),
    .valid (head_valid)
  );

`ifdef EXE_MEM_PIPE_SKID_EN
  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] skid_q;
  logic          skid_valid;
  logic          skid_load;
  logic          skid_drop;
  logic          head_from_skid;

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .load  (skid_load),
    .drop  (skid_drop),
    .d     (in_payload),
    .q     (skid_q),
    .valid (skid_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // All slot loads are suppressed under flush so held payload stays put.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    head_from_skid = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && !consume) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end else if (!accept && consume) begin
            head_drop = 1'b1;
            state_d   = ST_EMPTY;
          end else if (accept && consume) begin
            head_load = 1'b1;
          end
        end
        ST_SKID: begin
          if (consume && skid_valid) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign head_d   = head_from_skid ? skid_q : in_payload;
  assign in_ready = (state_q != ST_SKID);
`else
  assign head_load = accept;
  assign head_drop = consume;
  assign head_d    = in_payload;
  assign in_ready  = !head_valid || bus.out_ready;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = head_valid;
  assign bus.mem_r_en_out = head_q[PW-1] && head_valid;
  assign bus.mem_w_en_out = head_q[PW-2] && head_valid;
  assign bus.wb_en_out    = head_q[PW-3] && head_valid;
  assign bus.dest_out     = head_q[DEST_L +: REG_FILE_DEPTH];
  assign bus.alu_res_out  = head_q[WORD_WIDTH +: WORD_WIDTH];
  assign bus.val_rm_out   = head_q[0 +: WORD_WIDTH];

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg; covers both builds of EXE_MEM_PIPE_SKID_EN.
module tb_exe_mem_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exe_mem_pipe_reg_if #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4)) bus ();

  exe_mem_pipe_reg #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic v, input logic [31:0] alu, input logic wen);
    bus.in_valid    = v;
    bus.alu_res_in  = alu;
    bus.dest_in     = alu[3:0];
    bus.val_rm_in   = ~alu;
    bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = wen;
    bus.wb_en_in    = 1'b1;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    offer(1'b1, 32'hDEADBEEF, 1'b1);

    // Reset held with a live offer.
    cyc();
    cyc();
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_alu_res",   64'(bus.alu_res_out), 64'd0);
    check_eq("rst_val_rm",    64'(bus.val_rm_out), 64'd0);
    check_eq("rst_dest",      64'(bus.dest_out), 64'd0);
    check_eq("rst_ctrl",      64'({bus.mem_r_en_out, bus.mem_w_en_out, bus.wb_en_out}), 64'd0);
    check_eq("rst_in_ready",  64'(bus.in_ready), 64'd1);
    offer(1'b0, 32'hDEADBEEF, 1'b1);
    rst = 1'b1;
    cyc();
    check_eq("post_rst_no_entry", 64'(bus.out_valid), 64'd0);

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 32'(i), 1'b0);
      #1;
      check_eq("stream_in_ready", 64'(bus.in_ready), 64'd1);
      cyc();
      check_eq("stream_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stream_alu",   64'(bus.alu_res_out), 64'(i));
      check_eq("stream_dest",  64'(bus.dest_out), 64'(i % 16));
    end
    offer(1'b0, 32'd0, 1'b0);
    cyc();
    check_eq("stream_drained", 64'(bus.out_valid), 64'd0);

    // Stall with back-pressure.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h10, 1'b0);
    cyc();
    check_eq("stall_head", 64'(bus.alu_res_out), 64'h10);
`ifdef EXE_MEM_PIPE_SKID_EN
    check_eq("stall_rdy_full", 64'(bus.in_ready), 64'd1);
    offer(1'b1, 32'h11, 1'b0);
    cyc();
    check_eq("stall_rdy_skid", 64'(bus.in_ready), 64'd0);
    offer(1'b1, 32'h12, 1'b0);
    cyc();
    check_eq("stall_rdy_hold", 64'(bus.in_ready), 64'd0);
    check_eq("stall_hold_head", 64'(bus.alu_res_out), 64'h10);
    bus.out_ready = 1'b1;
    cyc();
    check_eq("stall_out_11", 64'(bus.alu_res_out), 64'h11);
    check_eq("stall_rdy_back", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("stall_out_12", 64'(bus.alu_res_out), 64'h12);
`else
    check_eq("stall_rdy_low", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    check_eq("stall_rdy_follow_hi", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
    #1;
    check_eq("stall_rdy_follow_lo", 64'(bus.in_ready), 64'd0);
    offer(1'b1, 32'h11, 1'b0);
    cyc();
    check_eq("stall_hold_head", 64'(bus.alu_res_out), 64'h10);
    bus.out_ready = 1'b1;
    cyc();
    check_eq("stall_out_11", 64'(bus.alu_res_out), 64'h11);
    offer(1'b1, 32'h12, 1'b0);
    cyc();
    check_eq("stall_out_12", 64'(bus.alu_res_out), 64'h12);
`endif
    check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
    offer(1'b0, 32'd0, 1'b0);
    cyc();
    check_eq("stall_drained", 64'(bus.out_valid), 64'd0);

    // Flush while holding entries; same-cycle offer 0xC must vanish.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'hA, 1'b1);
    cyc();
    offer(1'b1, 32'hB, 1'b1);
    cyc();
    check_eq("flush_pre_rdy", 64'(bus.in_ready), 64'd0);
    check_eq("flush_pre_wen", 64'(bus.mem_w_en_out), 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    offer(1'b1, 32'hC, 1'b1);
    cyc();
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 1'b0);
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_wen",   64'(bus.mem_w_en_out), 64'd0);
    check_eq("flush_hold",  64'(bus.alu_res_out), 64'hA);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("flush_no_emit", 64'(bus.out_valid), 64'd0);
    end

    // Bubble gating of control bits.
    offer(1'b1, 32'h55, 1'b1);
    cyc();
    check_eq("bub_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bub_wen_on", 64'(bus.mem_w_en_out), 64'd1);
    offer(1'b0, 32'h0, 1'b0);
    cyc();
    check_eq("bub_gone", 64'(bus.out_valid), 64'd0);
    check_eq("bub_wen_off", 64'(bus.mem_w_en_out), 64'd0);
    check_eq("bub_wb_off", 64'(bus.wb_en_out), 64'd0);
    check_eq("bub_alu_hold", 64'(bus.alu_res_out), 64'h55);

    // Asynchronous reset between edges while full.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h77, 1'b0);
    cyc();
    offer(1'b0, 32'h0, 1'b0);
    check_eq("arst_pre_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_alu",   64'(bus.alu_res_out), 64'd0);
    #1;
    rst = 1'b1;
    cyc();
    check_eq("arst_after", 64'(bus.out_valid), 64'd0);
    check_eq("arst_rdy",   64'(bus.in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
